// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3 responder backed by a word-wide on-chip SRAM. Independent read and
//   write engines, one outstanding burst each; INCR, FIXED and WRAP bursts of
//   1-16 beats. Out-of-window beats answer DECERR (reads return 0, writes are
//   dropped). Illegal WRAP lengths and the reserved burst type are served as
//   INCR with SLVERR.
// Ports
//   aclk, aresetn                        clock, synchronous active-low reset
//   ar*  (arid/araddr/arlen/arsize/arburst, arvalid/arready)   read address
//   r*   (rid/rdata/rresp/rlast, rvalid/rready)                read data
//   aw*  (awid/awaddr/awlen/awsize/awburst, awvalid/awready)   write address
//   w*   (wid ignored, wdata/wstrb/wlast, wvalid/wready)       write data
//   b*   (bid/bresp, bvalid/bready)                            write response
module axi_sram_slave #(
   parameter int          MEM_AW    = 14,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          RD_GAP    = 0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned DEPTH       = 2 ** MEM_AW;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [1:0]  BURST_WRAP  = 2'b10;
   localparam logic [15:0] GAP_LAST    = 16'(RD_GAP > 0 ? RD_GAP - 1 : 0);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_GAP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step, mask;
      step = 32'd1 << size;
      mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      case (burst)
         BURST_FIXED: next_addr = a;
         BURST_WRAP:  next_addr = (a & ~mask) | ((a + step) & mask);
         default:     next_addr = a + step;
      endcase
   endfunction

   function automatic logic bad_burst(input logic [7:0] len, input logic [1:0] burst);
      bad_burst = (burst == 2'b11) ||
                  (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
   endfunction

   // Response codes are ordered so that a plain unsigned max is the worst one.
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      worst = (a > b) ? a : b;
   endfunction

   logic [31:0] mem [DEPTH];

   // Outputs stay 0 for the first cycle after reset, including the ready flags.
   logic live;

   r_state_t          r_state, r_next;
   logic [3:0]        r_id;
   logic [31:0]       r_addr, rdata_q;
   logic [7:0]        r_len, r_beat;
   logic [2:0]        r_size;
   logic [1:0]        r_burst, rresp_q;
   logic              r_err, r_hit;
   logic [15:0]       gap_cnt;
   logic [32:0]       r_off;
   logic [MEM_AW-1:0] r_idx;

   w_state_t          w_state, w_next;
   logic [3:0]        w_id;
   logic [31:0]       w_addr;
   logic [7:0]        w_len, w_beat;
   logic [2:0]        w_size;
   logic [1:0]        w_burst, w_resp, w_beat_resp;
   logic              w_hit, w_fire, w_end;
   logic [32:0]       w_off;
   logic [MEM_AW-1:0] w_idx;

   logic spare_unused;
   assign spare_unused = ^{wid, r_off[1:0], w_off[1:0]};

   // 33-bit offset: a borrow (address below BASE_ADDR) lands in the top bit.
   assign r_off = {1'b0, r_addr} - {1'b0, BASE_ADDR};
   assign r_hit = (r_off[32:MEM_AW+2] == '0);
   assign r_idx = r_off[MEM_AW+1:2];
   assign w_off = {1'b0, w_addr} - {1'b0, BASE_ADDR};
   assign w_hit = (w_off[32:MEM_AW+2] == '0);
   assign w_idx = w_off[MEM_AW+1:2];

   // ---------------- read engine ----------------
   always_ff @(posedge aclk) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = live;
            if (arvalid && live) r_next = R_ADDR;
         end
         R_ADDR: r_next = R_DATA;
         R_DATA: begin
            rvalid = 1'b1;
            rlast  = (r_beat == r_len);
            if (rready) begin
               if (r_beat == r_len) r_next = R_IDLE;
               else if (RD_GAP > 0) r_next = R_GAP;
               else                 r_next = R_ADDR;
            end
         end
         R_GAP: if (gap_cnt == GAP_LAST) r_next = R_ADDR;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         live    <= 1'b0;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_err   <= 1'b0;
         r_beat  <= '0;
         rdata_q <= '0;
         rresp_q <= '0;
         gap_cnt <= '0;
      end else begin
         live <= 1'b1;
         if (r_state == R_IDLE && arvalid && arready) begin
            r_id    <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= bad_burst(arlen, arburst) ? BURST_INCR : arburst;
            r_err   <= bad_burst(arlen, arburst);
            r_beat  <= '0;
         end
         // rdata/rresp only load here, so they hold while the master stalls.
         if (r_state == R_ADDR) begin
            rdata_q <= r_hit ? mem[r_idx] : '0;
            rresp_q <= !r_hit ? RESP_DECERR : (r_err ? RESP_SLVERR : RESP_OKAY);
         end
         if (r_state == R_DATA && rready) begin
            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
            r_beat <= r_beat + 8'd1;
         end
         gap_cnt <= (r_state == R_GAP) ? gap_cnt + 16'd1 : '0;
      end
   end

   assign rid   = r_id;
   assign rdata = rdata_q;
   assign rresp = rresp_q;

   // ---------------- write engine ----------------
   assign w_fire      = (w_state == W_DATA) && wvalid;
   assign w_end       = wlast || (w_beat == w_len);
   assign w_beat_resp = !w_hit ? RESP_DECERR :
                        (wlast != (w_beat == w_len)) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge aclk) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = live;
            if (awvalid && live) w_next = W_DATA;
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid && w_end) w_next = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_beat  <= '0;
         w_resp  <= '0;
      end else begin
         if (w_state == W_IDLE && awvalid && awready) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= bad_burst(awlen, awburst) ? BURST_INCR : awburst;
            w_resp  <= bad_burst(awlen, awburst) ? RESP_SLVERR : RESP_OKAY;
            w_beat  <= '0;
         end
         if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_beat <= w_beat + 8'd1;
            w_resp <= worst(w_resp, w_beat_resp);
         end
      end
   end

   // SRAM array has no reset so its contents survive aresetn.
   always_ff @(posedge aclk) begin
      if (aresetn && w_fire && w_hit) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign bid   = w_id;
   assign bresp = w_resp;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Self-checking bench for axi_sram_slave. Read bursts come from a vector
//   table; expected beats go into a scoreboard queue when a request is issued
//   and are popped by a monitor on the falling edge whenever R or B completes.
//   Hand sequences cover latency, rready stall, write responses and reset.
module tb_axi_sram_slave;

   localparam int          MEM_AW = 14;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [63:0] WIN_LO = {32'd0, BASE};
   localparam logic [63:0] WIN_HI = {32'd0, BASE} + (64'd4 << MEM_AW);

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic [3:0]  wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   axi_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE), .RD_GAP(0)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [1:0]  resp_in;   // expected rresp for beats inside the window
   } rvec_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   rexp_t       r_exp[$];
   bexp_t       b_exp[$];
   rexp_t       mon_r;
   bexp_t       mon_b;
   logic [31:0] mm [int];
   logic [31:0] wbuf [16];
   logic [3:0]  sbuf [16];
   rvec_t       rv [8];
   int          n_vec = 0;
   int          n_miss = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic bit m_inwin(input logic [31:0] a);
      logic [63:0] a64;
      a64 = {32'd0, a};
      return (a64 >= WIN_LO) && (a64 < WIN_HI);
   endfunction

   function automatic int m_key(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step, cont, base;
      step = 32'd1 << size;
      if (burst == 2'b00) return a;
      if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
         cont = ({24'd0, len} + 32'd1) * step;
         base = (a / cont) * cont;
         return base + ((a - base + step) % cont);
      end
      return a + step;
   endfunction

   task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp_in);
      rexp_t       e;
      logic [31:0] a;
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         e.id   = id;
         e.last = (b == int'(len));
         if (m_inwin(a)) begin
            e.data = mm.exists(m_key(a)) ? mm[m_key(a)] : 32'hDEAD_0000;
            e.resp = resp_in;
         end else begin
            e.data = '0;
            e.resp = 2'b11;
         end
         r_exp.push_back(e);
         a = m_next(a, len, size, burst);
      end
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      bit ok;
      ok = 0;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge aclk);
         if (arready) begin
            @(posedge aclk);
            #1;
            ok = 1;
            break;
         end
      end
      arvalid = 1'b0;
      if (!ok) chk("ar_handshake_timeout", 32'(ok), 32'd1);
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      bit ok;
      ok = 0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge aclk);
         if (awready) begin
            @(posedge aclk);
            #1;
            ok = 1;
            break;
         end
      end
      awvalid = 1'b0;
      if (!ok) chk("aw_handshake_timeout", 32'(ok), 32'd1);
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
      bit ok;
      ok = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge aclk);
         if (wready) begin
            @(posedge aclk);
            #1;
            ok = 1;
            break;
         end
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      if (!ok) chk("w_handshake_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_r_left(input int n);
      for (int t = 0; t < 300 && r_exp.size() > n; t++) @(posedge aclk);
      if (r_exp.size() > n) begin
         chk("r_beats_timeout", 32'(r_exp.size()), 32'(n));
         r_exp.delete();
      end
      #1;
   endtask

   task automatic wait_b_empty();
      for (int t = 0; t < 100 && b_exp.size() > 0; t++) @(posedge aclk);
      if (b_exp.size() > 0) begin
         chk("b_timeout", 32'(b_exp.size()), 32'd0);
         b_exp.delete();
      end
      #1;
   endtask

   // Sends nbeats beats from wbuf/sbuf; wlast is raised on the final one only
   // when final_last is set. exp_b is the hand-derived burst response.
   task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input bit final_last,
                           input logic [1:0] exp_b);
      bexp_t       e;
      logic [31:0] a, w;
      e.id = id;
      e.resp = exp_b;
      b_exp.push_back(e);
      a = addr;
      for (int b = 0; b < nbeats; b++) begin
         if (m_inwin(a)) begin
            w = mm.exists(m_key(a)) ? mm[m_key(a)] : '0;
            for (int j = 0; j < 4; j++) if (sbuf[b][j]) w[8*j +: 8] = wbuf[b][8*j +: 8];
            mm[m_key(a)] = w;
         end
         a = m_next(a, len, 3'd2, burst);
      end
      aw_send(id, addr, len, burst);
      for (int b = 0; b < nbeats; b++) w_beat(wbuf[b], sbuf[b], (b == nbeats - 1) ? final_last : 1'b0);
      wait_b_empty();
   endtask

   always @(negedge aclk) begin
      if (aresetn) begin
         if (rvalid && rready) begin
            if (r_exp.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL r_unexpected: got beat id=%0h data=0x%08h, want no beat", rid, rdata);
            end else begin
               mon_r = r_exp.pop_front();
               chk("rdata", rdata, mon_r.data);
               chk("rresp", 32'(rresp), 32'(mon_r.resp));
               chk("rlast", 32'(rlast), 32'(mon_r.last));
               chk("rid", 32'(rid), 32'(mon_r.id));
            end
         end
         if (bvalid && bready) begin
            if (b_exp.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL b_unexpected: got bid=%0h bresp=%0d, want no response", bid, bresp);
            end else begin
               mon_b = b_exp.pop_front();
               chk("bresp", 32'(bresp), 32'(mon_b.resp));
               chk("bid", 32'(bid), 32'(mon_b.id));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit, want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] cap_d;
      logic [3:0]  cap_id;
      logic        cap_l;

      rv[0] = '{4'h1, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 2'b00};
      rv[1] = '{4'h2, 32'h0000_0108, 8'd3, 3'd2, 2'b10, 2'b00};
      rv[2] = '{4'h3, 32'h0000_013C, 8'd7, 3'd2, 2'b10, 2'b00};
      rv[3] = '{4'h4, 32'h0000_0080, 8'd2, 3'd2, 2'b00, 2'b00};
      rv[4] = '{4'h5, 32'h0000_0100, 8'd3, 3'd1, 2'b01, 2'b00};
      rv[5] = '{4'h6, 32'h0000_0100, 8'd2, 3'd2, 2'b10, 2'b10};
      rv[6] = '{4'h7, 32'h0000_0040, 8'd1, 3'd2, 2'b11, 2'b10};
      rv[7] = '{4'h8, 32'h0001_0000, 8'd0, 3'd2, 2'b01, 2'b00};

      aresetn = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      rready = 1'b1; bready = 1'b1;

      repeat (3) @(posedge aclk);
      #1;
      chk("rst_ctrl", 32'({arready, rvalid, rlast, awready, wready, bvalid}), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ids_resp", 32'({rid, bid, rresp, bresp}), 32'd0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      chk("arready_idle", 32'(arready), 32'd1);
      chk("awready_idle", 32'(awready), 32'd1);

      // Preload word[i] = i for i in 0..127 with 16-beat INCR bursts.
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 16; j++) begin
            wbuf[j] = 32'(k * 16 + j);
            sbuf[j] = 4'hF;
         end
         wr_burst(4'(k), 32'(k * 64), 8'd15, 2'b01, 16, 1'b1, 2'b00);
      end

      // First beat appears in the second cycle after the AR handshake cycle.
      push_read(4'h1, 32'h100, 8'd3, 3'd2, 2'b01, 2'b00);
      ar_send(4'h1, 32'h100, 8'd3, 3'd2, 2'b01);
      chk("arready_busy", 32'(arready), 32'd0);
      chk("rvalid_c1", 32'(rvalid), 32'd0);
      @(posedge aclk);
      #1;
      chk("rvalid_c2", 32'(rvalid), 32'd1);
      wait_r_left(0);

      for (int i = 0; i < 8; i++) begin
         push_read(rv[i].id, rv[i].addr, rv[i].len, rv[i].size, rv[i].burst, rv[i].resp_in);
         ar_send(rv[i].id, rv[i].addr, rv[i].len, rv[i].size, rv[i].burst);
         wait_r_left(0);
      end

      // Writes: prefill, strobed INCR, early wlast, window edge, missing wlast, WRAP.
      wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
      wr_burst(4'h2, 32'h24, 8'd0, 2'b01, 1, 1'b1, 2'b00);
      wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'hF;
      wbuf[1] = 32'h1122_3344; sbuf[1] = 4'h3;
      wr_burst(4'hA, 32'h20, 8'd1, 2'b01, 2, 1'b1, 2'b00);
      wbuf[0] = 32'h5555_0000; wbuf[1] = 32'h5555_0001; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      wr_burst(4'h3, 32'h200, 8'd3, 2'b01, 2, 1'b1, 2'b10);
      wbuf[0] = 32'h7777_1111; wbuf[1] = 32'h7777_2222;
      wr_burst(4'h4, 32'hFFFC, 8'd1, 2'b01, 2, 1'b1, 2'b11);
      wbuf[0] = 32'h0BAD_F00D;
      wr_burst(4'h5, 32'h210, 8'd0, 2'b01, 1, 1'b0, 2'b10);
      wbuf[0] = 32'hC0DE_0089; wbuf[1] = 32'hC0DE_0088;
      wr_burst(4'h6, 32'h224, 8'd1, 2'b10, 2, 1'b1, 2'b00);

      // Readbacks of the written words.
      push_read(4'h9, 32'h20, 8'd1, 3'd2, 2'b01, 2'b00);
      ar_send(4'h9, 32'h20, 8'd1, 3'd2, 2'b01);
      wait_r_left(0);
      chk("mdl_word8", mm[8], 32'hAABB_CCDD);
      chk("mdl_word9", mm[9], 32'hFFFF_3344);
      push_read(4'hB, 32'h200, 8'd1, 3'd2, 2'b01, 2'b00);
      ar_send(4'hB, 32'h200, 8'd1, 3'd2, 2'b01);
      wait_r_left(0);
      push_read(4'hC, 32'hFFFC, 8'd1, 3'd2, 2'b01, 2'b00);
      ar_send(4'hC, 32'hFFFC, 8'd1, 3'd2, 2'b01);
      wait_r_left(0);
      push_read(4'hD, 32'h210, 8'd0, 3'd2, 2'b01, 2'b00);
      ar_send(4'hD, 32'h210, 8'd0, 3'd2, 2'b01);
      wait_r_left(0);
      push_read(4'hE, 32'h220, 8'd1, 3'd2, 2'b10, 2'b00);
      ar_send(4'hE, 32'h220, 8'd1, 3'd2, 2'b10);
      wait_r_left(0);

      // rready low mid-burst: outputs must hold, no beat lost or repeated.
      push_read(4'hF, 32'h100, 8'd7, 3'd2, 2'b01, 2'b00);
      ar_send(4'hF, 32'h100, 8'd7, 3'd2, 2'b01);
      wait_r_left(5);
      rready = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge aclk);
         if (rvalid) break;
      end
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      cap_d = rdata; cap_id = rid; cap_l = rlast;
      for (int t = 0; t < 5; t++) begin
         @(negedge aclk);
         chk("hold_rvalid", 32'(rvalid), 32'd1);
         chk("hold_rdata", rdata, cap_d);
         chk("hold_rid", 32'(rid), 32'(cap_id));
         chk("hold_rlast", 32'(rlast), 32'(cap_l));
      end
      @(posedge aclk);
      #1;
      rready = 1'b1;
      wait_r_left(0);

      // Reset during an 8-beat read with a write burst still open.
      aw_send(4'h9, 32'h180, 8'd3, 2'b01);
      mm[m_key(32'h180)] = 32'hDEAD_BEEF;
      w_beat(32'hDEAD_BEEF, 4'hF, 1'b0);
      push_read(4'h5, 32'h140, 8'd7, 3'd2, 2'b01, 2'b00);
      ar_send(4'h5, 32'h140, 8'd7, 3'd2, 2'b01);
      wait_r_left(6);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      chk("mid_rst_ctrl", 32'({arready, rvalid, rlast, awready, wready, bvalid}), 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      chk("mid_rst_ids_resp", 32'({rid, bid, rresp, bresp}), 32'd0);
      r_exp.delete();
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      push_read(4'h6, 32'h104, 8'd0, 3'd2, 2'b01, 2'b00);
      ar_send(4'h6, 32'h104, 8'd0, 3'd2, 2'b01);
      wait_r_left(0);
      push_read(4'h7, 32'h180, 8'd0, 3'd2, 2'b01, 2'b00);
      ar_send(4'h7, 32'h180, 8'd0, 3'd2, 2'b01);
      wait_r_left(0);
      repeat (20) @(posedge aclk);
      #1;
      chk("idle_after_reset", 32'({rvalid, bvalid, arready, awready}), 32'b0011);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
